// File: rtl/delay_sweep_ctrl.sv
// Tap-sweep sequencer for the 7-tap delay line: flush, fire one pulse, time dout, compare.
// Optional DELAY_SWEEP_ERRMAP_EN adds a per-tap sticky fault map on err_map[7:0].
module delay_sweep_ctrl #(
    parameter int unsigned ADDR_MIN = 1,
    parameter int unsigned ADDR_MAX = 6,
    parameter int unsigned LAT_OFS  = 1,
    parameter int unsigned FLUSH_N  = 8,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       dout,
    output logic       din,
    output logic [2:0] addr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] meas
`ifdef DELAY_SWEEP_ERRMAP_EN
    ,
    output logic [7:0] err_map
`endif
);

    localparam int unsigned FW = $clog2(FLUSH_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_FIRE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cnt_inc;
    logic [3:0]    exp_lat;
    logic [2:0]    addr_q, addr_d;
    logic [3:0]    meas_q, meas_d;
    logic          err_q, err_d;
    logic          din_q, din_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef DELAY_SWEEP_ERRMAP_EN
    logic [7:0]    map_q, map_d;
`endif

    assign cnt_inc = cnt_q + 4'd1;
    assign exp_lat = {1'b0, addr_q} + 4'(LAT_OFS);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        meas_d  = meas_q;
        err_d   = err_q;
`ifdef DELAY_SWEEP_ERRMAP_EN
        map_d   = map_q;
`endif
        case (state_q)
            S_IDLE: begin
                addr_d = 3'(ADDR_MIN);
                if (start) begin
                    err_d   = 1'b0;
`ifdef DELAY_SWEEP_ERRMAP_EN
                    map_d   = '0;
`endif
                    fcnt_d  = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == FW'(FLUSH_N - 1)) begin
                    fcnt_d  = '0;
                    state_d = S_FIRE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_FIRE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A dout hit on the timeout cycle still counts as a valid measurement.
                if (dout) begin
                    meas_d  = cnt_inc;
                    state_d = S_CHECK;
                end else if (cnt_inc == 4'(TIMEOUT)) begin
                    meas_d  = 4'hF;
                    err_d   = 1'b1;
`ifdef DELAY_SWEEP_ERRMAP_EN
                    map_d[addr_q] = 1'b1;
`endif
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (meas_q != exp_lat) begin
                    err_d = 1'b1;
`ifdef DELAY_SWEEP_ERRMAP_EN
                    map_d[addr_q] = 1'b1;
`endif
                end
                if (addr_q == 3'(ADDR_MAX)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 3'd1;
                    fcnt_d  = '0;
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                addr_d  = 3'(ADDR_MIN);
                state_d = S_IDLE;
            end
            default: begin
                addr_d  = 3'(ADDR_MIN);
                state_d = S_IDLE;
            end
        endcase
`ifdef DELAY_SWEEP_ERRMAP_EN
        err_d = |map_d;
`endif
        // Outputs are registered from the next state so they line up with state_q.
        din_d  = (state_d == S_FIRE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= 3'(ADDR_MIN);
            meas_q  <= '0;
            err_q   <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DELAY_SWEEP_ERRMAP_EN
            map_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            meas_q  <= meas_d;
            err_q   <= err_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DELAY_SWEEP_ERRMAP_EN
            map_q   <= map_d;
`endif
        end
    end

    assign din  = din_q;
    assign addr = addr_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign meas = meas_q;
`ifdef DELAY_SWEEP_ERRMAP_EN
    assign err_map = map_q;
`endif

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed bench for delay_sweep_ctrl with a behavioural delay-line model and a per-tap scoreboard.
module tb_delay_sweep_ctrl;

    localparam int ADDR_MIN = 1;
    localparam int ADDR_MAX = 6;
    localparam int LAT_OFS  = 1;
    localparam int FLUSH_N  = 8;
    localparam int TIMEOUT  = 15;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       dout;
    logic       din;
    logic [2:0] addr;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] meas;
`ifdef DELAY_SWEEP_ERRMAP_EN
    logic [7:0] err_map;
`endif

    int n_vec = 0;
    int n_err = 0;

    // line model: 0 = ideal (addr+1), 1 = stuck at delay 4, 2 = dout tied low
    int          mode = 0;
    logic        glitch = 1'b0;
    logic [15:0] sr;

    typedef struct {
        logic [2:0] a;
        logic [3:0] m;
    } exp_t;
    exp_t sb[$];

    delay_sweep_ctrl #(
        .ADDR_MIN(ADDR_MIN),
        .ADDR_MAX(ADDR_MAX),
        .LAT_OFS (LAT_OFS),
        .FLUSH_N (FLUSH_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .start(start),
        .dout (dout),
        .din  (din),
        .addr (addr),
        .busy (busy),
        .done (done),
        .err  (err),
        .meas (meas)
`ifdef DELAY_SWEEP_ERRMAP_EN
        ,
        .err_map(err_map)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr) begin
        if (!clr) sr <= '0;
        else      sr <= {sr[14:0], din};
    end

    always_comb begin
        case (mode)
            0:       dout = sr[addr];
            1:       dout = sr[3];
            default: dout = 1'b0;
        endcase
        dout = dout | glitch;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // smode: 0 pulse start, 1 raise and hold start, 2 start already high (drop it after first cycle)
    // inject: 0 none, 1 start pulse during tap 2 flush, 2 dout glitch during tap 2 flush
    task automatic run_sweep(input int md, input int smode, input int inject, input int abort_tap);
        exp_t e;
        logic exp_err;
        bit   first;
        int   c;
        int   m;
        mode    = md;
        exp_err = 1'b0;
        for (int a = ADDR_MIN; a <= ADDR_MAX; a++) begin
            m = (md == 0) ? a + 1 : (md == 1) ? 4 : 15;
            if (m != a + LAT_OFS) exp_err = 1'b1;
            sb.push_back('{a: 3'(a), m: 4'(m)});
        end
        if (smode != 2) start = 1'b1;
        first = 1'b1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c = 0;
            do begin
                @(negedge clk);
                c++;
                if (first) begin
                    first = 1'b0;
                    if (smode != 1) start = 1'b0;
                    chk("err_clr_on_start", {7'd0, err}, 8'd0);
                end
                if (int'(e.a) == ADDR_MIN + 1 && c == 3) begin
                    if (inject == 1) start = 1'b1;
                    if (inject == 2) glitch = 1'b1;
                end
                if (int'(e.a) == ADDR_MIN + 1 && c == 4) begin
                    if (inject == 1) start = 1'b0;
                    glitch = 1'b0;
                end
            end while (!din && c < 40);
            chk("flush_len", 8'(c), 8'(FLUSH_N + 1));
            chk("tap_addr", {5'd0, addr}, {5'd0, e.a});
            if (!din) begin
                sb.delete();
                return;
            end
            if (int'(e.a) == abort_tap) begin
                sb.delete();
                @(negedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
            chk("din_one_cycle", {7'd0, din}, 8'd0);
            repeat (int'(e.m)) @(negedge clk);
            chk("meas", {4'd0, meas}, {4'd0, e.m});
            chk("addr_in_check", {5'd0, addr}, {5'd0, e.a});
            chk("busy_in_check", {7'd0, busy}, 8'd1);
        end
        @(negedge clk);
        chk("done_pulse", {7'd0, done}, 8'd1);
        chk("busy_in_done", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk("done_drop", {7'd0, done}, 8'd0);
        chk("busy_idle", {7'd0, busy}, 8'd0);
        chk("addr_idle", {5'd0, addr}, 8'(ADDR_MIN));
        chk("err_end", {7'd0, err}, {7'd0, exp_err});
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_din"},  {7'd0, din},  8'd0);
        chk({tag, "_addr"}, {5'd0, addr}, 8'(ADDR_MIN));
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_err"},  {7'd0, err},  8'd0);
        chk({tag, "_meas"}, {4'd0, meas}, 8'd0);
    endtask

    initial begin
        clr   = 1'b0;
        start = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // ideal line
        run_sweep(0, 0, 0, -1);

        // line stuck at delay 4 on every tap
        run_sweep(1, 0, 0, -1);
`ifdef DELAY_SWEEP_ERRMAP_EN
        chk("err_map_stuck", err_map, 8'b0111_0110);
`endif

        // dead line: every tap times out
        run_sweep(2, 0, 0, -1);
`ifdef DELAY_SWEEP_ERRMAP_EN
        chk("err_map_dead", err_map, 8'b0111_1110);
`endif

        // glitch during flush, err from previous sweep must clear
        run_sweep(0, 0, 2, -1);

        // abort mid-WAIT on tap 4
        run_sweep(0, 0, 0, 4);
        chk("pre_abort_busy", {7'd0, busy}, 8'd1);
        #2 clr = 1'b0;
        #1;
        chk_reset_outputs("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {7'd0, done}, 8'd0);
        end
        clr = 1'b1;
        @(negedge clk);
        run_sweep(0, 0, 0, -1);

        // start held high: one sweep, then a second starts right after IDLE
        run_sweep(0, 1, 0, -1);
        run_sweep(0, 2, 1, -1);
        repeat (3) @(negedge clk);
        chk("no_restart", {7'd0, busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
